flash_prom_rd_cntrlr: RTL and testbench

- Single-clock, parametrised read controller for the board's parallel NOR flash PROM. It is the successor of the dual-clock flash read path.
- Serves CPU/BIOS reads through a req/ready handshake: byte reads, aligned word reads, and unaligned word reads.
- Wait-state count and address widths are set by parameters.
- Sits between the CPU memory-mapped ROM decode and the NF_* board pins.

---
 rtl/flash_prom_rd_cntrlr_if.sv | 13 +
 rtl/flash_prom_rd_cntrlr.sv | 171 +++++++++++++++++
 tb/tb_flash_prom_rd_cntrlr.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_prom_rd_cntrlr_if.sv
// CPU-side read handshake between the ROM decode and the flash PROM read controller.
interface flash_prom_rd_cntrlr_if #(
    parameter int AW = 17
);
    logic [AW-1:0] addr;
    logic          byte_m;
    logic          req;
    logic [15:0]   rd_data;
    logic          ready;

    modport master (output addr, byte_m, req, input rd_data, ready);
    modport slave  (input addr, byte_m, req, output rd_data, ready);
endinterface

// File: rtl/flash_prom_rd_cntrlr.sv
// Parallel NOR flash read controller: byte, aligned and unaligned word reads; optional one-entry cache (FLASH_RDCACHE_EN).
// Latency WAIT_CYC+1 (2*WAIT_CYC+1 unaligned, 1 on cache hit); req is only sampled in IDLE, so callers simply hold it.
module flash_prom_rd_cntrlr #(
    parameter int AW       = 17,
    parameter int FA_W     = 21,
    parameter int WAIT_CYC = 4
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    flash_prom_rd_cntrlr_if.slave  bus,
    output logic                   NF_WE,
    output logic                   NF_BYTE,
    output logic                   NF_CE,
    output logic                   NF_OE,
    output logic [FA_W-1:0]        NF_A,
    input  logic [15:0]            NF_D
);
    typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_t;

    localparam int             CW       = $clog2(WAIT_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [AW-2:0]  WA_ONE   = {{(AW-2){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [AW-2:0] nf_addr;
    logic          byte_q, a0_q, sec_q;
    logic [15:0]   w0;
    logic          cnt_last;
    logic          sec_in;
    logic          hit;

    assign cnt_last = (cnt == CNT_LAST);
    assign sec_in   = !bus.byte_m && bus.addr[0];
    assign NF_WE    = 1'b1;
    assign NF_BYTE  = 1'b1;
    assign NF_A     = FA_W'(nf_addr);

`ifdef FLASH_RDCACHE_EN
    logic [AW-2:0] c_tag;
    logic [15:0]   c0;
    logic [7:0]    c1;
    logic          v0, v1;

    assign hit = v0 && (bus.addr[AW-1:1] == c_tag) && (!sec_in || v1);
`else
    assign hit = 1'b0;
`endif

    // lo holds the first word, hi the low byte of the following word
    function automatic logic [15:0] fmt(input logic [15:0] lo, input logic [7:0] hi,
                                        input logic bm, input logic a0);
        logic [7:0] b;
        b = a0 ? lo[15:8] : lo[7:0];
        if (bm)
            return {{8{b[7]}}, b};
        else if (a0)
            return {hi, lo[15:8]};
        else
            return lo;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.ready = 1'b0;
        NF_CE     = 1'b1;
        NF_OE     = 1'b1;
        case (state)
            IDLE: begin
                if (bus.req)
                    state_nxt = hit ? DONE : RD0;
            end
            RD0: begin
                NF_CE = 1'b0;
                NF_OE = 1'b0;
                if (cnt_last)
                    state_nxt = sec_q ? RD1 : DONE;
            end
            RD1: begin
                NF_CE = 1'b0;
                NF_OE = 1'b0;
                if (cnt_last)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt         <= '0;
            nf_addr     <= '0;
            byte_q      <= 1'b0;
            a0_q        <= 1'b0;
            sec_q       <= 1'b0;
            w0          <= '0;
            bus.rd_data <= '0;
`ifdef FLASH_RDCACHE_EN
            v0          <= 1'b0;
            v1          <= 1'b0;
            c_tag       <= '0;
            c0          <= '0;
            c1          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        byte_q  <= bus.byte_m;
                        a0_q    <= bus.addr[0];
                        sec_q   <= sec_in;
                        nf_addr <= bus.addr[AW-1:1];
                        cnt     <= '0;
`ifdef FLASH_RDCACHE_EN
                        if (hit)
                            bus.rd_data <= fmt(c0, c1, bus.byte_m, bus.addr[0]);
`endif
                    end
                end
                RD0: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        w0  <= NF_D;
                        if (sec_q) begin
                            nf_addr <= nf_addr + WA_ONE;
                        end else begin
                            bus.rd_data <= fmt(NF_D, 8'h00, byte_q, a0_q);
`ifdef FLASH_RDCACHE_EN
                            c_tag <= nf_addr;
                            c0    <= NF_D;
                            v0    <= 1'b1;
                            v1    <= 1'b0;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RD1: begin
                    if (cnt_last) begin
                        cnt         <= '0;
                        bus.rd_data <= fmt(w0, NF_D[7:0], byte_q, a0_q);
`ifdef FLASH_RDCACHE_EN
                        // nf_addr already points at the second word; tag is the first
                        c_tag <= nf_addr - WA_ONE;
                        c0    <= w0;
                        c1    <= NF_D[7:0];
                        v0    <= 1'b1;
                        v1    <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_prom_rd_cntrlr.sv
module tb_flash_prom_rd_cntrlr;
    localparam int AW   = 17;
    localparam int FA_W = 21;
    localparam int W    = 4;

    logic            sys_clk = 1'b0;
    logic            reset   = 1'b1;
    logic            NF_WE, NF_BYTE, NF_CE, NF_OE;
    logic [FA_W-1:0] NF_A;
    logic [15:0]     NF_D;

    logic [FA_W-1:0] ov_a0 = FA_W'(32'h10);
    logic [FA_W-1:0] ov_a1 = FA_W'(32'h11);
    logic [15:0]     ov_d0 = 16'hA55A;
    logic [15:0]     ov_d1 = 16'h0F0F;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef FLASH_RDCACHE_EN
    bit          m_v0 = 1'b0;
    bit          m_v1 = 1'b0;
    int          m_t  = 0;
    logic [15:0] m_c0 = '0;
    logic [7:0]  m_c1 = '0;
`endif

    flash_prom_rd_cntrlr_if #(.AW(AW)) bus ();

    flash_prom_rd_cntrlr #(.AW(AW), .FA_W(FA_W), .WAIT_CYC(W)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus),
        .NF_WE   (NF_WE),
        .NF_BYTE (NF_BYTE),
        .NF_CE   (NF_CE),
        .NF_OE   (NF_OE),
        .NF_A    (NF_A),
        .NF_D    (NF_D)
    );

    always #5 sys_clk = ~sys_clk;

    // flash array: two programmable words, everything else a fixed hash of the address
    function automatic logic [15:0] flash_word(input logic [FA_W-1:0] a,
                                               input logic [FA_W-1:0] oa0, input logic [15:0] od0,
                                               input logic [FA_W-1:0] oa1, input logic [15:0] od1);
        logic [31:0] h;
        if (a == oa0) return od0;
        if (a == oa1) return od1;
        h = 32'(a) * 32'h9E3779B1;
        return h[31:16] ^ h[15:0];
    endfunction

    assign NF_D = (!NF_CE && !NF_OE) ? flash_word(NF_A, ov_a0, ov_d0, ov_a1, ov_d1) : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic void model_reset();
`ifdef FLASH_RDCACHE_EN
        m_v0 = 1'b0;
        m_v1 = 1'b0;
`endif
    endfunction

    // reference: what a read of byte address a returns and how long it takes
    function automatic void model_access(input logic [AW-1:0] a, input bit bm,
                                         output logic [15:0] d, output int lat,
                                         output bit hit, output bit two);
        int          wa, wb;
        logic [15:0] w0, w1;
        logic [7:0]  b;
        bit          sec;
        wa  = int'(a) / 2;
        wb  = (wa + 1) % (1 << (AW - 1));
        sec = !bm && a[0];
        w0  = flash_word(FA_W'(wa), ov_a0, ov_d0, ov_a1, ov_d1);
        w1  = flash_word(FA_W'(wb), ov_a0, ov_d0, ov_a1, ov_d1);
        hit = 1'b0;
`ifdef FLASH_RDCACHE_EN
        if (m_v0 && m_t == wa && (!sec || m_v1)) begin
            hit = 1'b1;
            w0  = m_c0;
            w1  = {8'h00, m_c1};
        end else begin
            m_v0 = 1'b1;
            m_t  = wa;
            m_c0 = w0;
            m_c1 = w1[7:0];
            m_v1 = sec;
        end
`endif
        two = !hit && sec;
        lat = hit ? 1 : (sec ? 2 * W + 1 : W + 1);
        b   = a[0] ? w0[15:8] : w0[7:0];
        if (bm)        d = {{8{b[7]}}, b};
        else if (a[0]) d = {w1[7:0], w0[15:8]};
        else           d = w0;
    endfunction

    // call at a negedge with the controller idle; returns one negedge after the ready pulse
    task automatic do_read(input logic [AW-1:0] a, input bit bm, input string tag,
                           output logic [15:0] obs);
        logic [15:0]     ed;
        int              el, k, ce_n, wa, wb;
        bit              hit, two, got;
        logic [FA_W-1:0] fa, la;
        wa = int'(a) / 2;
        wb = (wa + 1) % (1 << (AW - 1));
        model_access(a, bm, ed, el, hit, two);
        bus.addr   = a;
        bus.byte_m = bm;
        bus.req    = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.req    = 1'b0;
        bus.addr   = AW'($urandom);
        bus.byte_m = 1'($urandom);
        k = 0; got = 1'b0; ce_n = 0; fa = '0; la = '0; obs = '0;
        while (!got && k < 64) begin
            @(negedge sys_clk);
            k++;
            if (!NF_CE && !NF_OE) begin
                if (ce_n == 0) fa = NF_A;
                la = NF_A;
                ce_n++;
            end
            if (bus.ready) begin
                got = 1'b1;
                obs = bus.rd_data;
            end
        end
        chk({tag, "_lat"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'(el));
        chk({tag, "_data"}, 32'(obs), 32'(ed));
        chk({tag, "_ce_cycles"}, 32'(ce_n), hit ? 32'd0 : (two ? 32'(2 * W) : 32'(W)));
        if (ce_n > 0) begin
            chk({tag, "_nfa_first"}, 32'(fa), 32'(wa));
            chk({tag, "_nfa_last"}, 32'(la), two ? 32'(wb) : 32'(wa));
        end
        @(negedge sys_clk);
        chk({tag, "_ready_pulse"}, 32'(bus.ready), 32'd0);
        chk({tag, "_hold"}, 32'(bus.rd_data), 32'(ed));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] obs, d1, d2;
        int          l1, l2, t1, t2, pulses;
        bit          h, two;
        logic [AW-1:0] prev, a;

        bus.req = 1'b0; bus.addr = '0; bus.byte_m = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_nf_a", 32'(NF_A), 32'd0);
        chk("rst_nf_ce", 32'(NF_CE), 32'd1);
        chk("rst_nf_oe", 32'(NF_OE), 32'd1);
        chk("nf_we", 32'(NF_WE), 32'd1);
        chk("nf_byte", 32'(NF_BYTE), 32'd1);
        reset = 1'b0;
        model_reset();
        @(negedge sys_clk);

        do_read(17'h00020, 1'b0, "w_aligned", obs);
        chk("tp_a55a", 32'(obs), 32'h0000A55A);
        do_read(17'h00021, 1'b1, "b_hi", obs);
        chk("tp_ffa5", 32'(obs), 32'h0000FFA5);
        do_read(17'h00020, 1'b1, "b_lo", obs);
        chk("tp_005a", 32'(obs), 32'h0000005A);
        do_read(17'h00020, 1'b0, "w_repeat", obs);
        chk("tp_repeat", 32'(obs), 32'h0000A55A);

        ov_d0 = 16'h1234;
        ov_d1 = 16'hBEEF;
        do_read(17'h00021, 1'b0, "w_unaligned", obs);
        chk("tp_ef12", 32'(obs), 32'h0000EF12);

        do_read(17'h1FFFF, 1'b0, "w_wrap", obs);

        // reset three cycles into an unaligned access
        bus.addr = 17'h00021; bus.byte_m = 1'b0; bus.req = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.req = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge sys_clk);
            if (bus.ready) pulses++;
        end
        reset = 1'b1;
        @(negedge sys_clk);
        chk("abort_rd_data", 32'(bus.rd_data), 32'd0);
        chk("abort_nf_ce", 32'(NF_CE), 32'd1);
        chk("abort_nf_a", 32'(NF_A), 32'd0);
        reset = 1'b0;
        model_reset();
        repeat (2 * W + 2) begin
            @(negedge sys_clk);
            if (bus.ready) pulses++;
        end
        chk("abort_no_ready", 32'(pulses), 32'd0);
        do_read(17'h00021, 1'b0, "after_abort", obs);

        // req held high: two back-to-back accesses
        model_access(17'h00040, 1'b0, d1, l1, h, two);
        model_access(17'h00040, 1'b0, d2, l2, h, two);
        bus.addr = 17'h00040; bus.byte_m = 1'b0; bus.req = 1'b1;
        @(posedge sys_clk);
        t1 = -1; t2 = -1; pulses = 0; obs = '0;
        for (int k = 1; k <= 60 && pulses < 2; k++) begin
            @(negedge sys_clk);
            if (bus.ready) begin
                pulses++;
                if (pulses == 1) begin
                    t1 = k;
                    obs = bus.rd_data;
                end else begin
                    t2 = k;
                    bus.req = 1'b0;
                    chk("b2b_data2", 32'(bus.rd_data), 32'(d2));
                end
            end
        end
        bus.req = 1'b0;
        chk("b2b_lat1", 32'(t1), 32'(l1));
        chk("b2b_data1", 32'(obs), 32'(d1));
        chk("b2b_lat2", 32'(t2), 32'(l1 + 1 + l2));
        @(negedge sys_clk);

        prev = 17'h00020;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       a = AW'($urandom);
                1:       a = 17'h1FFFE | AW'($urandom_range(0, 1));
                2:       a = 17'h00020 + AW'($urandom_range(0, 3));
                default: a = prev;
            endcase
            do_read(a, 1'($urandom), $sformatf("rnd%0d", i), obs);
            prev = a;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
